// File: rtl/stereo_data_mem_pkg.sv
// Shared sizing, sample/address types and FSM encoding for the stereo sample store.
package stereo_mem_pkg;

  localparam int DW         = 16;
  localparam int DEPTH      = 256;
  localparam int AW         = $clog2(DEPTH);
  localparam int ZERO_LIMIT = 800;
  localparam int ZCW        = $clog2(ZERO_LIMIT + 1);

  typedef logic signed [DW-1:0] sample_t;
  typedef logic [AW-1:0]        addr_t;
  typedef logic [ZCW-1:0]       zcnt_t;

  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);
  localparam zcnt_t ZLIMIT    = zcnt_t'(ZERO_LIMIT);

  // FLUSH encodes as zero so the reset value is the all-zero state.
  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } mem_state_e;

endpackage : stereo_mem_pkg

// File: rtl/stereo_data_mem_zero_run_detect.sv
// Per-channel run-length detector for consecutive zero samples; raises sleep
// once ZERO_LIMIT zeros have been written back to back.
module zero_run_detect
  import stereo_mem_pkg::*;
(
  input  logic          DCLK,
  input  logic          clear,
  input  logic [DW-1:0] sample,
  input  logic          wr_en,
  input  logic          sync_clr,
  output logic          sleep
);

  zcnt_t cnt_q, cnt_d;
  logic  sleep_q, sleep_d;

  // Next zero-run count and sleep flag; a history flush wins over a write.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = cnt_q;
    sleep_d = sleep_q;
    if (sync_clr) begin
      cnt_d   = '0;
      sleep_d = 1'b0;
    end else if (wr_en) begin
      if (sample == '0) begin
        if (cnt_q != ZLIMIT) cnt_d = cnt_q + zcnt_t'(1);
      end else begin
        cnt_d = '0;
      end
      sleep_d = (cnt_d == ZLIMIT);
    end
  end

  // Counter and sleep registers.
  always_ff @(posedge DCLK or negedge clear) begin
    if (!clear) begin
      cnt_q   <= '0;
      sleep_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_q   <= cnt_d;
      sleep_q <= sleep_d;
    end
  end

  assign sleep = sleep_q;

endmodule : zero_run_detect

// File: rtl/stereo_data_mem.sv
// Stereo sample store: circular per-channel history with a registered lookback
// read port, a self-zeroing FLUSH state and per-channel zero-run sleep flags.
module stereo_data_mem
  import stereo_mem_pkg::*;
(
  input  logic          DCLK,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_l,
  input  logic [DW-1:0] in_r,
  input  logic          flush,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_l,
  output logic [DW-1:0] rd_r,
  output logic          rd_valid,
  output logic          busy,
  output logic          new_sample,
  output logic          drop,
  output logic          sleep_l,
  output logic          sleep_r
);

  mem_state_e    state_q, state_d;
  addr_t         flush_cnt_q, flush_cnt_d;
  addr_t         wr_ptr_q, wr_ptr_d;
  logic          new_sample_q, new_sample_d;
  logic          drop_q, drop_d;
  logic [DW-1:0] rd_l_q, rd_l_d;
  logic [DW-1:0] rd_r_q, rd_r_d;
  logic          rd_valid_q, rd_valid_d;

  logic          ram_we;
  addr_t         ram_addr;
  logic [DW-1:0] ram_wl, ram_wr;
  logic          accept;
  logic          zero_clr;
  addr_t         rd_addr;

  logic [DW-1:0] mem_l [DEPTH];
  logic [DW-1:0] mem_r [DEPTH];

  // FSM next state, write port steering and status pulses.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    new_sample_d = 1'b0;
    drop_d       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = wr_ptr_q;
    ram_wl       = in_l;
    ram_wr       = in_r;
    accept       = 1'b0;
    zero_clr     = 1'b0;
    unique case (state_q)
      FLUSH: begin
        ram_we      = 1'b1;
        ram_addr    = flush_cnt_q;
        ram_wl      = '0;
        ram_wr      = '0;
        flush_cnt_d = flush_cnt_q + addr_t'(1);
        drop_d      = in_valid;
        if (flush_cnt_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        if (flush) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
          wr_ptr_d    = '0;
          zero_clr    = 1'b1;
          drop_d      = in_valid;
        end else if (in_valid) begin
          ram_we       = 1'b1;
          accept       = 1'b1;
          wr_ptr_d     = wr_ptr_q + addr_t'(1);
          new_sample_d = 1'b1;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  // Lookback read: address relative to the pre-write pointer, zero while flushing.
  always_comb begin
    rd_addr    = wr_ptr_q - addr_t'(1) - rd_idx;
    rd_valid_d = rd_en && (state_q == RUN);
    rd_l_d     = '0;
    rd_r_d     = '0;
    if (rd_valid_d) begin
      rd_l_d = mem_l[rd_addr];
      rd_r_d = mem_r[rd_addr];
    end
  end

  // Control and read-data registers.
  always_ff @(posedge DCLK or negedge clear) begin
    if (!clear) begin
      state_q      <= FLUSH;
      flush_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      new_sample_q <= 1'b0;
      drop_q       <= 1'b0;
      rd_l_q       <= '0;
      rd_r_q       <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      new_sample_q <= new_sample_d;
      drop_q       <= drop_d;
      rd_l_q       <= rd_l_d;
      rd_r_q       <= rd_r_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // History RAM write port.
  always_ff @(posedge DCLK) begin
    // NOTE: no reset on the arrays so they map to block RAM; FLUSH does the zeroing.
    if (ram_we) begin
      mem_l[ram_addr] <= ram_wl;
      mem_r[ram_addr] <= ram_wr;
    end
  end

  zero_run_detect u_zero_l (
    .DCLK     (DCLK),
    .clear    (clear),
    .sample   (in_l),
    .wr_en    (accept),
    .sync_clr (zero_clr),
    .sleep    (sleep_l)
  );

  zero_run_detect u_zero_r (
    .DCLK     (DCLK),
    .clear    (clear),
    .sample   (in_r),
    .wr_en    (accept),
    .sync_clr (zero_clr),
    .sleep    (sleep_r)
  );

  assign busy       = (state_q == FLUSH);
  assign new_sample = new_sample_q;
  assign drop       = drop_q;
  assign rd_l       = rd_l_q;
  assign rd_r       = rd_r_q;
  assign rd_valid   = rd_valid_q;

endmodule : stereo_data_mem

// File: tb/tb_stereo_data_mem.sv
// Self-checking bench for stereo_data_mem: directed scenarios plus random
// traffic, compared every cycle against a queue-based history model.
module tb_stereo_data_mem;

  logic        DCLK = 1'b0;
  logic        clear = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_l = '0;
  logic [15:0] in_r = '0;
  logic        flush = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_idx = '0;
  logic [15:0] rd_l, rd_r;
  logic        rd_valid, busy, new_sample, drop, sleep_l, sleep_r;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  stereo_data_mem dut (
    .DCLK       (DCLK),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_l       (in_l),
    .in_r       (in_r),
    .flush      (flush),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_l       (rd_l),
    .rd_r       (rd_r),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .new_sample (new_sample),
    .drop       (drop),
    .sleep_l    (sleep_l),
    .sleep_r    (sleep_r)
  );

  always #5 DCLK = ~DCLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] s16(input int v);
    logic [15:0] t;
    t = 16'(v);
    return {16'b0, t};
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] hl[$];
  logic [15:0] hr[$];
  int          flush_left = 256;
  int          zl = 0, zr = 0;
  logic        m_busy = 1'b1, m_new = 1'b0, m_drop = 1'b0;
  logic        m_rd_valid = 1'b0, m_rd_chk = 1'b0;
  logic [15:0] m_rd_l = '0, m_rd_r = '0;

  function automatic logic [15:0] look(input logic [15:0] h[$], input int k);
    if (k < h.size()) return h[h.size() - 1 - k];
    return 16'h0;
  endfunction

  always @(posedge DCLK or negedge clear) begin
    if (!clear) begin
      hl.delete(); hr.delete();
      flush_left = 256; zl = 0; zr = 0;
      m_busy = 1'b1; m_new = 1'b0; m_drop = 1'b0;
      m_rd_valid = 1'b0; m_rd_chk = 1'b0; m_rd_l = '0; m_rd_r = '0;
    end else begin
      m_rd_chk   = rd_en;
      m_rd_valid = rd_en && !m_busy;
      m_rd_l     = m_rd_valid ? look(hl, int'(rd_idx)) : 16'h0;
      m_rd_r     = m_rd_valid ? look(hr, int'(rd_idx)) : 16'h0;
      m_new      = 1'b0;
      m_drop     = 1'b0;
      if (m_busy) begin
        m_drop = in_valid;
        flush_left--;
      end else if (flush) begin
        m_drop = in_valid;
        flush_left = 256;
        hl.delete(); hr.delete();
        zl = 0; zr = 0;
      end else if (in_valid) begin
        hl.push_back(in_l); hr.push_back(in_r);
        if (hl.size() > 256) begin void'(hl.pop_front()); void'(hr.pop_front()); end
        zl = (in_l == 0) ? ((zl < 800) ? zl + 1 : 800) : 0;
        zr = (in_r == 0) ? ((zr < 800) ? zr + 1 : 800) : 0;
        m_new = 1'b1;
      end
      m_busy = (flush_left > 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge DCLK) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      check("new_sample", 32'(new_sample), 32'(m_new));
      check("drop", 32'(drop), 32'(m_drop));
      check("sleep_l", 32'(sleep_l), 32'(zl == 800));
      check("sleep_r", 32'(sleep_r), 32'(zr == 800));
      if (m_rd_chk) begin
        check("rd_l", {16'b0, rd_l}, {16'b0, m_rd_l});
        check("rd_r", {16'b0, rd_r}, {16'b0, m_rd_r});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge DCLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int exp_len);
    int n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    if (exp_len >= 0) check(nm, 32'(n), 32'(exp_len));
    else if (n >= 1000) check(nm, 32'(n), 32'd0);
  endtask

  task automatic write_pair(input int l, input int r);
    in_valid = 1'b1; in_l = 16'(l); in_r = 16'(r);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read_at(input int k);
    rd_en = 1'b1; rd_idx = 8'(k);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("flush_wait", -1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #1 clear = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_l", {16'b0, rd_l}, 32'd0);
    repeat (3) tick();
    clear = 1'b1;
    wait_idle("busy_len_reset", 256);

    // Entire freshly flushed history reads back as zero.
    for (int i = 0; i < 256; i++) begin
      read_at(i);
      check("init_rd_l", {16'b0, rd_l}, 32'd0);
    end

    // Five pairs, then lookbacks at the newest, oldest and one past oldest.
    for (int n = 1; n <= 5; n++) write_pair(n, -n);
    read_at(0);
    check("lit_rd0_l", {16'b0, rd_l}, s16(5));
    check("lit_rd0_r", {16'b0, rd_r}, s16(-5));
    check("lit_rd0_v", 32'(rd_valid), 32'd1);
    read_at(4);
    check("lit_rd4_l", {16'b0, rd_l}, s16(1));
    check("lit_rd4_r", {16'b0, rd_r}, s16(-1));
    read_at(5);
    check("lit_rd5_l", {16'b0, rd_l}, s16(0));
    check("lit_rd5_r", {16'b0, rd_r}, s16(0));

    // Wrap-around: 300 samples leave 45..300 in the window.
    do_flush();
    for (int n = 1; n <= 300; n++) write_pair(n, int'($urandom_range(0, 65535)));
    read_at(0);
    check("lit_wrap_rd0", {16'b0, rd_l}, s16(300));
    read_at(255);
    check("lit_wrap_rd255", {16'b0, rd_l}, s16(45));

    // Zero run on the left channel only.
    for (int n = 1; n <= 800; n++) begin
      write_pair(0, 7);
      if (n == 799) check("lit_sleep_l_799", 32'(sleep_l), 32'd0);
    end
    check("lit_sleep_l_800", 32'(sleep_l), 32'd1);
    check("lit_sleep_r_800", 32'(sleep_r), 32'd0);
    write_pair(1, 7);
    check("lit_sleep_l_wake", 32'(sleep_l), 32'd0);

    // Flush colliding with a write: sample dropped, history zeroed, pointer at 0.
    for (int n = 1; n <= 10; n++) write_pair(n + 100, n);
    flush = 1'b1; in_valid = 1'b1; in_l = 16'd123; in_r = 16'd321;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("lit_flush_drop", 32'(drop), 32'd1);
    check("lit_flush_sleep", 32'(sleep_l), 32'd0);
    wait_idle("busy_len_flush", 256);
    read_at(0);
    check("lit_after_flush_rd0", {16'b0, rd_l}, 32'd0);
    write_pair(77, -77);
    read_at(0);
    check("lit_first_write_l", {16'b0, rd_l}, s16(77));
    read_at(1);
    check("lit_first_write_prev", {16'b0, rd_l}, s16(0));

    // Reset arriving 100 cycles into a flush restarts the full flush.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (100) tick();
    clear = 1'b0;
    #1;
    check("lit_midrst_busy", 32'(busy), 32'd1);
    check("lit_midrst_drop", 32'(drop), 32'd0);
    check("lit_midrst_new", 32'(new_sample), 32'd0);
    check("lit_midrst_rdv", 32'(rd_valid), 32'd0);
    tick();
    clear = 1'b1;
    wait_idle("busy_len_midrst", 256);

    // Random traffic: mixed writes, reads, rare flushes, zero-heavy samples.
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_l     = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
      in_r     = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
      rd_en    = ($urandom_range(0, 1) == 0);
      rd_idx   = 8'($urandom);
      flush    = ($urandom_range(0, 599) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stereo_data_mem

// File: doc/stereo_data_mem.md
Name: stereo_data_mem

Overview:
Stereo sample store that sits directly downstream of the serial-to-parallel converter. Each completed 16-bit left/right word pair is written into a circular per-channel history of DEPTH entries. A lookback read port lets the FIR datapath fetch x[n-k]. Per-channel consecutive-zero counters flag sleep conditions for the top-level controller.

Parameters:
DEPTH, 256, history entries per channel (power of two)
AW, 8, address width, log2(DEPTH)
DW, 16, sample width
ZERO_LIMIT, 800, consecutive zero samples before a channel sleeps

Ports:
DCLK  in  1  system clock; all logic on posedge
clear  in  1  asynchronous active-low reset
in_valid  in  1  one-cycle pulse: in_l/in_r hold a complete word pair
in_l  in  DW  left sample, two's complement
in_r  in  DW  right sample, two's complement
flush  in  1  synchronous request to zero both histories
rd_en  in  1  lookback read request
rd_idx  in  AW  lookback offset k; 0 = newest sample
rd_l  out  DW  left x[n-k]
rd_r  out  DW  right x[n-k]
rd_valid  out  1  rd_l/rd_r valid this cycle
busy  out  1  flush in progress
new_sample  out  1  one-cycle pulse, cycle after an accepted write
drop  out  1  one-cycle pulse: in_valid arrived while busy or flush
sleep_l  out  1  left channel asleep
sleep_r  out  1  right channel asleep

Behaviour:
- Reset (clear=0), asynchronous. Outputs and state go to:
  - wr_ptr=0; zero counters=0
  - rd_l=rd_r=0; rd_valid=0; new_sample=0; drop=0; sleep_l=sleep_r=0
  - FSM=FLUSH; busy=1
- RAM contents are not reset. Zeroing is done only by the FLUSH state.
- FSM has two states, FLUSH and RUN.
- FLUSH:
  - Writes 0 to both channels at address flush_cnt, one entry per cycle.
  - flush_cnt runs 0..DEPTH-1, so the state lasts exactly DEPTH cycles.
  - After the write at address DEPTH-1, the FSM moves to RUN and busy drops.
  - busy=1 for all DEPTH cycles.
  - Entering FLUSH (from reset or from flush=1) also does: wr_ptr=0, zero counters=0, sleep_l=sleep_r=0.
- RUN, flush=1: go to FLUSH on the next cycle with flush_cnt=0.
  - flush has priority over in_valid in the same cycle.
  - That sample is discarded and drop pulses.
- RUN, in_valid=1 and flush=0:
  - Write in_l/in_r at wr_ptr.
  - wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
  - new_sample pulses one cycle later.
- in_valid while busy: discarded, drop pulses, no state change.
- Read:
  - Address = (wr_ptr - 1 - rd_idx) mod DEPTH.
  - Registered with 1-cycle latency: rd_en at cycle t gives data and rd_valid=1 at t+1.
  - rd_en while busy returns 0 with rd_valid=0.
- Read and write in the same cycle: the read uses the pre-write wr_ptr. The result is the history as it stood before that write.
- Reads older than the number of samples written since the last flush return 0, because the history was zeroed.
- Zero detection, per channel, updated on each accepted write:
  - Sample == 0: counter increments, saturating at ZERO_LIMIT.
  - Sample != 0: counter clears to 0.
  - sleep_x is registered: it sets on the write that makes the counter reach ZERO_LIMIT and clears on the write of a nonzero sample.
- Counter width: ceil(log2(ZERO_LIMIT+1)) bits.
- Channels are independent. Sleep does not block writes.
- Reset mid-operation, including mid-flush: state returns to the reset values and FLUSH restarts at address 0.

Decomposition:
- Package stereo_mem_pkg holds:
  - Parameters: DW, DEPTH, AW, ZERO_LIMIT
  - Typedefs: sample_t (logic signed [DW-1:0]) and addr_t
  - The enum for FSM states FLUSH/RUN
- One sub-module, zero_run_detect:
  - Instantiated once per channel.
  - Inputs: sample, write strobe, sync clear.
  - Output: sleep flag.
- RAM is inferred inline as two DEPTH x DW arrays.

Test Plan:
- Reset then idle -> busy=1 for exactly 256 cycles, then 0; rd_en with rd_idx=0..255 returns 0 on both channels.
- Write L=1..5, R=-1..-5 -> rd_idx=0 gives L=5/R=-5 one cycle after rd_en; rd_idx=4 gives 1/-1; rd_idx=5 gives 0/0; new_sample pulses once per write.
- Write 300 samples L=n (n=1..300) -> wr_ptr=44; rd_idx=0 gives 300; rd_idx=255 gives 45.
- 800 zero writes on L with R=7 -> sleep_l rises on the 800th write and sleep_r stays 0; write L=1 -> sleep_l=0 next cycle.
- Write 10 samples, then flush and in_valid together -> drop pulse; busy for 256 cycles; rd_idx=0 gives 0; the next write lands at address 0.
- Assert clear at cycle 100 of a flush -> outputs at reset values; busy stays 1 for a full 256 further cycles.
